// File: rtl/packet_assembler_if.sv
// Packet assembler bus: picker-side selection (header/subpackets) and the
// island timing in; serialised pixel data and the prefetch pulse out.
//   data_island_period : high for every pixel of a data island
//   header / sub       : current packet selection from the picker
//   packet_pixel_counter, packet_enable, packet_data, packet_data_valid :
//                        assembler outputs toward the picker and TERC4 encoder
interface packet_assembler_if;
    logic                  data_island_period;
    logic [23:0]           header;
    logic [3:0][55:0]      sub;
    logic [4:0]            packet_pixel_counter;
    logic                  packet_enable;
    logic [8:0]            packet_data;
    logic                  packet_data_valid;

    modport master (
        output data_island_period, header, sub,
        input  packet_pixel_counter, packet_enable, packet_data, packet_data_valid
    );

    modport slave (
        input  data_island_period, header, sub,
        output packet_pixel_counter, packet_enable, packet_data, packet_data_valid
    );
endinterface

// File: rtl/packet_assembler.sv
// HDMI data-island packet assembler. Serialises one 32-pixel packet per 32
// clocks: header bit (+ BCH(32,24) parity) on bit 0, subpacket even/odd bits
// (+ BCH(64,56) parity) on bits [8:1]. The header/subpackets are taken straight
// from the bus at pixel 0 and from shadow copies for pixels 1..31, so the
// picker may move on to the next packet right after packet_enable.
// Ports:
//   clk_pixel : pixel clock, rising edge
//   reset_n   : asynchronous active-low reset
//   pif       : slave side of packet_assembler_if
module packet_assembler (
    input  logic               clk_pixel,
    input  logic               reset_n,
    packet_assembler_if.slave  pif
);

    logic [4:0]       cnt_q, cnt_d;
    logic [23:0]      hdr_q, hdr_src;
    logic [3:0][55:0] sub_q, sub_src;
    logic [7:0]       ecc_h_q, ecc_h_d;
    logic [3:0][7:0]  ecc_s_q, ecc_s_d;
    logic [8:0]       data_q, data_d;
    logic             vld_q;
    logic             first;

    // One serial BCH step, LSB-first LFSR with polynomial taps 8'h83.
    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
        return (e >> 1) ^ ((e[0] ^ b) ? 8'h83 : 8'h00);
    endfunction

    assign first = (cnt_q == 5'd0);

    assign pif.packet_enable        = pif.data_island_period & first;
    assign pif.packet_pixel_counter = cnt_q;
    assign pif.packet_data          = data_q;
    assign pif.packet_data_valid    = vld_q;

    always_comb begin
        cnt_d   = pif.data_island_period ? cnt_q + 5'd1 : 5'd0;
        hdr_src = first ? pif.header : hdr_q;
        sub_src = first ? pif.sub    : sub_q;
        data_d  = '0;
        ecc_h_d = ecc_h_q;
        ecc_s_d = ecc_s_q;

        // Header channel: 24 data bits, then the 8 parity bits LSB first.
        // The accumulator restarts from zero on pixel 0.
        if (cnt_q < 5'd24) begin
            data_d[0] = hdr_src[cnt_q];
            ecc_h_d   = ecc_step(first ? 8'h00 : ecc_h_q, data_d[0]);
        end else begin
            data_d[0] = ecc_h_q[cnt_q[2:0]];
        end

        // Subpacket channels: two bits per pixel, stepped even then odd.
        for (int k = 0; k < 4; k++) begin
            if (cnt_q < 5'd28) begin
                data_d[1+k] = sub_src[k][{cnt_q, 1'b0}];
                data_d[5+k] = sub_src[k][{cnt_q, 1'b1}];
                ecc_s_d[k]  = ecc_step(ecc_step(first ? 8'h00 : ecc_s_q[k],
                                                data_d[1+k]), data_d[5+k]);
            end else begin
                data_d[1+k] = ecc_s_q[k][{cnt_q[1:0], 1'b0}];
                data_d[5+k] = ecc_s_q[k][{cnt_q[1:0], 1'b1}];
            end
        end

        // Outside an island nothing is emitted; the ECC state is simply
        // reseeded at the next pixel 0.
        if (!pif.data_island_period) begin
            data_d  = '0;
            ecc_h_d = ecc_h_q;
            ecc_s_d = ecc_s_q;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            hdr_q   <= '0;
            sub_q   <= '0;
            ecc_h_q <= '0;
            ecc_s_q <= '0;
            data_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ecc_h_q <= ecc_h_d;
            ecc_s_q <= ecc_s_d;
            data_q  <= data_d;
            vld_q   <= pif.data_island_period;
            if (pif.packet_enable) begin
                hdr_q <= pif.header;
                sub_q <= pif.sub;
            end
        end
    end

endmodule

// File: doc/packet_assembler.md
Name: packet_assembler

Overview:
- Downstream neighbour of the packet picker.
- Serialises one 32-pixel HDMI data-island packet per 32 clocks.
- Captures the selected header and four subpackets at the packet start, then computes the BCH ECC serially (header BCH(32,24), subpackets BCH(64,56)).
- Emits 9 bits per pixel to the TERC4 encoder, plus the pixel counter and a packet_enable pulse that tells the picker to prefetch the next packet.

Parameters:
- none

Ports:
- clk_pixel  in  1  pixel clock; all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- data_island_period  in  1  high for every pixel of a data island; island length is a multiple of 32
- header  in  24  packet header HB2..HB0, HB0 in bits [7:0]; sampled only when counter==0
- sub  in  4x56  subpackets 0..3, each SB6..SB0, SB0 in bits [7:0]; sampled only when counter==0
- packet_pixel_counter  out  5  current pixel index within the packet
- packet_enable  out  1  combinational: data_island_period & (packet_pixel_counter==0)
- packet_data  out  9  registered; [0]=header/ECC bit; [4:1]=even bits of sub 3..0; [8:5]=odd bits of sub 3..0
- packet_data_valid  out  1  registered; packet_data is meaningful

Behaviour:
- Async reset (reset_n=0): counter=0, packet_data=0, packet_data_valid=0, shadow header/sub=0, all ECC registers=0. packet_enable follows its equation, so it is 0 because data_island_period is low in reset.
- Counter:
  - data_island_period=1: increments every clock, wrapping 31->0.
  - data_island_period=0: forced to 0 on the next edge.
- Prefetch handshake:
  - In a cycle with c==0 and the island active, header/sub are loaded into the shadow registers and packet_enable is high.
  - The picker updates its selection on that edge; the new value is held until the next c==0, 32 clocks later.
  - The first packet of an island carries the selection prefetched at the previous packet start.
- Source select: at c==0 use the header/sub inputs directly; for c=1..31 use the shadow registers.
- ECC step: next = (ecc>>1) ^ ((ecc[0]^bit) ? 8'h83 : 8'h00).
  - At c==0 each ECC accumulator starts from 8'h00 before the first bit is applied.
- Header channel:
  - c=0..23: out bit = header[c]; ecc_h is stepped with that bit.
  - c=24..31: out bit = ecc_h[c-24], LSB first, no stepping.
- Subpacket k (0..3):
  - c=0..27: even bit = sub[k][2c], odd bit = sub[k][2c+1]; ecc_s[k] is stepped twice per clock, 2c first, then 2c+1.
  - c=28..31: even = ecc_s[k][2(c-28)], odd = ecc_s[k][2(c-28)+1].
  - Two sequential steps per clock: one 8-bit combinational chain, no lookahead required.
- Latency: packet_data and packet_data_valid are registered, so they appear 1 clock after the cycle in which counter==c.
  - packet_data_valid = data_island_period delayed by 1 clock.
  - When valid is 0, packet_data=0.
- Mid-packet deassert of data_island_period: the partial packet is abandoned; counter returns to 0; the shadow registers are kept; the ECC registers are reinitialised at the next c==0. No error flag.
- Back-to-back packets: at the c==31->0 boundary there is no bubble. The c==0 cycle reinitialises ECC and loads the shadow registers in the same edge on which the c==31 output is registered.
- Reset asserted mid-island: all state returns to reset values immediately; the first packet after reset uses the inputs sampled at the first c==0.

Test Plan:
- Null packet: island of 32 pixels, header=0, sub=0 -> packet_enable high exactly at c=0; packet_data=9'h000 for all 32 valid pixels; valid high for 32 clocks, starting 1 clock after island rises.
- Header ECC: header=24'h000001, sub=0 -> packet_data[0] =1 at pixel 0, 0 at pixels 1..23; pixels 24..31 carry 8'h4A LSB first (0,1,0,1,0,0,1,0).
- Subpacket mapping: sub[2]=56'h1, others 0 -> packet_data[3] =1 at pixel 0, all other subpacket data bits 0 through pixel 27; pixels 28..31 carry ecc_s[2], which must match a bench LFSR model.
- Prefetch: 64-pixel island; the header input changes from A to B one clock after the first packet_enable -> packet 1 carries A; packet 2 carries B; exactly two packet_enable pulses, 32 clocks apart.
- Abort: drop data_island_period at c=10 -> counter 0 next clock; valid low 1 clock later. Restart the island with header=24'h000001 -> full packet with ECC 8'h4A, unaffected by the aborted packet.
- Async reset at c=17 -> packet_data=0, valid=0, counter=0 immediately without a clock edge; after release, a fresh island behaves as in the Null packet scenario.
